vec_compare_monitor: RTL and testbench

VEC_COMPARE_MONITOR -- requirements
Module: vec_compare_monitor

---
 rtl/vec_compare_monitor.sv | 147 ++++++++++++++
 tb/tb_vec_compare_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_compare_monitor.sv
// Compares a reference and a device output bundle sample-by-sample during a run and keeps
// per-field error counts, first-mismatch indices and a sample count, readable via rd_sel.
module vec_compare_monitor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic [2:0]       outv_ref,
  input  logic             o2_ref,
  input  logic             o1_ref,
  input  logic             o0_ref,
  input  logic [2:0]       outv_dut,
  input  logic             o2_dut,
  input  logic             o1_dut,
  input  logic             o0_dut,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Slot 0 is the total, slots 1..4 are outv, o2, o1, o0.
  localparam int unsigned NumCnt = 5;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               samples_q, samples_d;
  logic [NumCnt-1:0][CNT_W-1:0]   err_q, err_d;
  logic [NumCnt-1:0][CNT_W-1:0]   first_q, first_d;
  logic                           overflow_q, overflow_d;
  logic                           mismatch_q, mismatch_d;
  logic [CNT_W-1:0]               rd_data_q, rd_data_d;
  logic [NumCnt-1:0]              diff;
  logic                           accept;
  logic                           saturated;

  always_comb begin
    diff[1] = (outv_ref != outv_dut);
    diff[2] = (o2_ref != o2_dut);
    diff[3] = (o1_ref != o1_dut);
    diff[4] = (o0_ref != o0_dut);
    diff[0] = |diff[4:1];
  end

  assign accept    = (state_q == StRun) && sample_valid;
  assign saturated = (samples_q == CntMax);

  always_comb begin
    state_d    = state_q;
    samples_d  = samples_q;
    err_d      = err_q;
    first_d    = first_q;
    overflow_d = overflow_q;
    mismatch_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          samples_d  = '0;
          err_d      = '0;
          first_d    = '1;
          overflow_d = 1'b0;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (saturated) begin
        // Dropped sample: not counted, not compared.
        overflow_d = 1'b1;
      end else begin
        samples_d  = samples_q + 1'b1;
        mismatch_d = diff[0];
        for (int i = 0; i < NumCnt; i++) begin
          if (diff[i]) begin
            if (err_q[i] != CntMax) begin
              err_d[i] = err_q[i] + 1'b1;
            end
            if (err_q[i] == '0) begin
              first_d[i] = samples_q;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      4'd0:    rd_data_d = samples_q;
      4'd1:    rd_data_d = err_q[0];
      4'd2:    rd_data_d = err_q[1];
      4'd3:    rd_data_d = err_q[2];
      4'd4:    rd_data_d = err_q[3];
      4'd5:    rd_data_d = err_q[4];
      4'd6:    rd_data_d = first_q[0];
      4'd7:    rd_data_d = first_q[1];
      4'd8:    rd_data_d = first_q[2];
      4'd9:    rd_data_d = first_q[3];
      4'd10:   rd_data_d = first_q[4];
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= StIdle;
      samples_q  <= '0;
      err_q      <= '0;
      first_q    <= '1;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      samples_q  <= samples_d;
      err_q      <= err_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign mismatch = mismatch_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vec_compare_monitor.sv
// Randomised and directed checks of vec_compare_monitor against a queue-based model of
// accepted samples; a second CNT_W=4 instance exercises saturation.
module tb_vec_compare_monitor;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sample_valid = 1'b0;
  logic [2:0]  outv_ref = '0, outv_dut = '0;
  logic        o2_ref = 0, o1_ref = 0, o0_ref = 0, o2_dut = 0, o1_dut = 0, o0_dut = 0;
  logic [3:0]  rd_sel = '0;
  logic [15:0] rd_data;
  logic        busy, done, mismatch, overflow;
  logic [3:0]  rd_data_s;
  logic        busy_s, done_s, mismatch_s, overflow_s;

  int n_checks = 0;
  int n_fail = 0;

  // Model: every accepted sample of the current run, as {outv, o2, o1, o0}.
  logic [5:0] q_ref[$];
  logic [5:0] q_dut[$];
  bit         m_run = 0, m_done = 0, exp_mm = 0;

  always #5 clk = ~clk;

  vec_compare_monitor #(.CNT_W(16)) u_dut (
    .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .sample_valid(sample_valid),
    .outv_ref(outv_ref), .o2_ref(o2_ref), .o1_ref(o1_ref), .o0_ref(o0_ref),
    .outv_dut(outv_dut), .o2_dut(o2_dut), .o1_dut(o1_dut), .o0_dut(o0_dut),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done), .mismatch(mismatch),
    .overflow(overflow)
  );

  vec_compare_monitor #(.CNT_W(4)) u_dut_small (
    .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .sample_valid(sample_valid),
    .outv_ref(outv_ref), .o2_ref(o2_ref), .o1_ref(o1_ref), .o0_ref(o0_ref),
    .outv_dut(outv_dut), .o2_dut(o2_dut), .o1_dut(o1_dut), .o0_dut(o0_dut),
    .rd_sel(rd_sel), .rd_data(rd_data_s), .busy(busy_s), .done(done_s),
    .mismatch(mismatch_s), .overflow(overflow_s)
  );

  function automatic logic [15:0] exp_stat(input int sel);
    logic [5:0] mask;
    int cnt, first, f;
    if (sel == 0) return 16'(q_ref.size());
    if (sel < 1 || sel > 10) return 16'h0000;
    f = (sel <= 5) ? sel - 1 : sel - 6;
    case (f)
      0:       mask = 6'h3F;
      1:       mask = 6'h38;
      2:       mask = 6'h04;
      3:       mask = 6'h02;
      default: mask = 6'h01;
    endcase
    cnt = 0;
    first = -1;
    foreach (q_ref[i]) begin
      if (((q_ref[i] ^ q_dut[i]) & mask) != 6'h00) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    if (sel <= 5) return 16'(cnt);
    return (first < 0) ? 16'hFFFF : 16'(first);
  endfunction

  // One clock with the given inputs; the model advances at the same edge.
  task automatic drive(input logic v, input logic [5:0] r, input logic [5:0] d,
                       input logic st, input logic sp);
    sample_valid = v;
    {outv_ref, o2_ref, o1_ref, o0_ref} = r;
    {outv_dut, o2_dut, o1_dut, o0_dut} = d;
    start = st;
    stop = sp;
    @(posedge clk);
    exp_mm = 0;
    if (m_run && v) begin
      q_ref.push_back(r);
      q_dut.push_back(d);
      exp_mm = (r != d);
    end
    if (!m_run && st) begin
      m_run = 1;
      m_done = 0;
      q_ref.delete();
      q_dut.delete();
    end else if (m_run && sp) begin
      m_run = 0;
      m_done = 1;
    end
    #1;
    sample_valid = 0;
    start = 0;
    stop = 0;
  endtask

  task automatic read_stat(input int sel, output logic [15:0] val, output logic [3:0] val_s);
    rd_sel = 4'(sel);
    @(posedge clk);
    #1;
    val = rd_data;
    val_s = rd_data_s;
  endtask

  task automatic apply_reset();
    #3;
    areset_n = 0;
    m_run = 0;
    m_done = 0;
    q_ref.delete();
    q_dut.delete();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    areset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [3:0]  vs;
    #2;
    n_checks++;
    if ({busy, done, mismatch, overflow, rd_data} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, mismatch, overflow, rd_data});
    end
    release_reset();
    read_stat(6, v, vs);
    n_checks++;
    if (v !== 16'hFFFF || vs !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_first_idx got=%h/%h want=ffff/f", v, vs);
    end
    read_stat(0, v, vs);
    n_checks++;
    if (v !== 16'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_samples got=%h busy=%b want=0 busy=0", v, busy);
    end
  endtask

  task automatic check_all_stats(input string name);
    logic [15:0] v;
    logic [3:0]  vs;
    for (int s = 0; s <= 10; s++) begin
      read_stat(s, v, vs);
      n_checks++;
      if (v !== exp_stat(s)) begin
        n_fail++;
        $display("FAIL %s sel=%0d got=%h want=%h", name, s, v, exp_stat(s));
      end
    end
  endtask

  task automatic test_match_run();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drive(1, 6'(i), 6'(i), 0, 0);
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q_ref.size() != 10) begin
      n_fail++;
      $display("FAIL match_done got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    check_all_stats("match_stats");
  endtask

  task automatic test_field_errors();
    logic [5:0] r, d;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      r = 6'(i * 7 + 1);
      d = r;
      if (i == 3) d = r ^ 6'b001_000;
      if (i == 5 || i == 7) d = r ^ 6'b000_010;
      drive(1, r, d, 0, 0);
      n_checks++;
      if (mismatch !== exp_mm) begin
        n_fail++;
        $display("FAIL field_mismatch_pulse idx=%0d got=%b want=%b", i, mismatch, exp_mm);
      end
    end
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL field_mismatch_idle got=%b want=0", mismatch);
    end
    check_all_stats("field_stats");
  endtask

  task automatic test_stop_sample();
    logic [15:0] v;
    logic [3:0]  vs;
    drive(0, 0, 0, 1, 0);
    drive(1, 6'h15, 6'h14, 0, 1);
    n_checks++;
    if (mismatch !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_same_cycle got mm=%b done=%b want mm=1 done=1", mismatch, done);
    end
    drive(1, 6'h15, 6'h2A, 0, 0);
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL done_sample_ignored got mm=%b want 0", mismatch);
    end
    read_stat(0, v, vs);
    n_checks++;
    if (v !== 16'd1) begin
      n_fail++;
      $display("FAIL stop_samples got=%0d want=1", v);
    end
    check_all_stats("stop_stats");
  endtask

  task automatic test_random();
    logic [5:0] r, d;
    logic       v;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 6'($urandom);
      d = ($urandom_range(0, 2) == 0) ? (r ^ 6'($urandom)) : r;
      drive(v, r, d, 1'($urandom_range(0, 7) == 0), 0);
      n_checks++;
      if (mismatch !== exp_mm || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL random_cycle i=%0d got mm=%b busy=%b want mm=%b busy=1",
                 i, mismatch, busy, exp_mm);
      end
    end
    drive(0, 0, 0, 0, 1);
    check_all_stats("random_stats");
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    logic [3:0]  vs;
    apply_reset();
    release_reset();
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 17; i++) begin
      drive(1, 6'(i), 6'(i), 0, 0);
      if (i == 15 || i == 16) begin
        n_checks++;
        if (overflow_s !== (i == 16)) begin
          n_fail++;
          $display("FAIL small_overflow after=%0d got=%b want=%b", i, overflow_s, i == 16);
        end
      end
    end
    drive(0, 0, 0, 0, 1);
    read_stat(0, v, vs);
    n_checks++;
    if (vs !== 4'd15 || overflow_s !== 1'b1 || overflow !== 1'b0 || v !== 16'd17) begin
      n_fail++;
      $display("FAIL overflow_samples got small=%0d ovf=%b big=%0d ovf=%b want 15,1,17,0",
               vs, overflow_s, v, overflow);
    end
    read_stat(1, v, vs);
    n_checks++;
    if (vs !== 4'd0) begin
      n_fail++;
      $display("FAIL small_errors got=%0d want=0", vs);
    end
  endtask

  task automatic test_reset_mid_run();
    rd_sel = 4'd1;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 6'(i), 6'(i) ^ 6'h01, 0, 0);
    n_checks++;
    if (rd_data !== 16'd3) begin
      n_fail++;
      $display("FAIL midrun_before got=%0d want=3", rd_data);
    end
    apply_reset();
    n_checks++;
    if ({busy, done, mismatch, overflow, rd_data} !== 20'h0) begin
      n_fail++;
      $display("FAIL midrun_async got=%h want=0", {busy, done, mismatch, overflow, rd_data});
    end
    release_reset();
    check_all_stats("after_reset_stats");
    drive(0, 0, 0, 1, 0);
    drive(1, 6'h03, 6'h03, 0, 0);
    drive(1, 6'h07, 6'h06, 0, 0);
    drive(0, 0, 0, 0, 1);
    check_all_stats("clean_run_stats");
  endtask

  task automatic test_rd_sel();
    logic [15:0] v;
    logic [3:0]  vs;
    read_stat(12, v, vs);
    n_checks++;
    if (v !== 16'h0) begin
      n_fail++;
      $display("FAIL rdsel_12 got=%h want=0", v);
    end
    read_stat(0, v, vs);
    rd_sel = 4'd6;
    #4;
    n_checks++;
    if (rd_data !== exp_stat(0)) begin
      n_fail++;
      $display("FAIL rdsel_latency_early got=%h want=%h", rd_data, exp_stat(0));
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_data !== exp_stat(6)) begin
      n_fail++;
      $display("FAIL rdsel_latency_late got=%h want=%h", rd_data, exp_stat(6));
    end
  endtask

  initial begin
    test_reset();
    test_match_run();
    test_field_errors();
    test_stop_sample();
    test_random();
    test_rd_sel();
    test_reset_mid_run();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
